// File: rtl/uart_pkg_defs.sv
// Shared UART definitions: bit-FSM encoding, default baud divisor and word byte order.
// The transmit-side packer uses the same byte-order convention.
package uart_pkg_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int UART_CLKS_PER_BIT = 868;
    localparam bit HI_BYTE_FIRST     = 1'b1;

    function automatic logic [15:0] pack_word(input logic [7:0] first, input logic [7:0] second);
        return HI_BYTE_FIRST ? {first, second} : {second, first};
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 receiver: 2-flop synchroniser plus bit FSM producing one byte per frame.
// byte_done / frame_err are single-cycle strobes raised during the mid-stop-bit sample cycle.
module uart_rx_byte
    import uart_pkg_defs::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta, rx_s;
    rx_state_t     state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    idx, idx_nx;
    logic [7:0]    shreg, shreg_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            shreg   <= shreg_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + 1'b1;
        idx_nx    = idx;
        shreg_nx  = shreg;
        byte_done = 1'b0;
        frame_err = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!rx_s) state_nx = START;
            end
            START: begin
                // A high line at mid start bit is a glitch, not a frame.
                if (cnt == HALF_M1) begin
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    state_nx = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nx        = '0;
                    shreg_nx[idx] = rx_s;
                    if (idx == 3'd7) state_nx = STOP;
                    else             idx_nx   = idx + 3'd1;
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed.
                if (cnt == FULL_M1) begin
                    cnt_nx    = '0;
                    state_nx  = IDLE;
                    byte_done = rx_s;
                    frame_err = !rx_s;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign rx_byte = shreg;

endmodule

// File: rtl/uart_unpkg.sv
// UART word unpacker: pairs received bytes into 16-bit words on a valid/ready output.
// A lone first byte is dropped after TIMEOUT_CLKS; a word arriving while the output is full is dropped.
module uart_unpkg
    import uart_pkg_defs::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int TIMEOUT_CLKS = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_rdy,
    output logic        frame_err,
    output logic        overrun
);

    localparam int TCW = $clog2(TIMEOUT_CLKS + 1);

    logic           byte_done, word_done;
    logic [7:0]     rx_byte, hi;
    logic           phase;
    logic [TCW-1:0] tcnt;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (uart_rx),
        .rx_byte   (rx_byte),
        .byte_done (byte_done),
        .frame_err (frame_err)
    );

    assign word_done = phase & byte_done;
    assign overrun   = word_done & out_valid & ~out_rdy;

    // Byte phase: byte_done takes priority over an expiring timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 1'b0;
            hi    <= '0;
            tcnt  <= '0;
        end else if (frame_err) begin
            phase <= 1'b0;
        end else if (byte_done) begin
            if (!phase) begin
                hi    <= rx_byte;
                phase <= 1'b1;
                tcnt  <= '0;
            end else begin
                phase <= 1'b0;
            end
        end else if (phase) begin
            if (tcnt == TCW'(TIMEOUT_CLKS - 1)) phase <= 1'b0;
            else                                tcnt  <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (word_done && (!out_valid || out_rdy)) begin
            out_data  <= pack_word(hi, rx_byte);
            out_valid <= 1'b1;
        end else if (out_valid && out_rdy) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_unpkg.sv
// Bench for uart_unpkg: directed scenarios plus randomized byte pairs against a word-queue model.
module tb_uart_unpkg;

    localparam int CPB = 16;
    localparam int TO  = 400;
    // 2 synchroniser flops + 1 idle-detect cycle, then 9.5 bit times to mid stop bit.
    localparam int LAT = 3 + 9 * CPB + CPB / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_rx;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_rdy;
    logic        frame_err;
    logic        overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] got[$];
    int n_ferr, n_ovr, n_vhigh, t_valid;
    logic prev_valid;

    uart_unpkg #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_rdy   (out_rdy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_rdy) got.push_back(out_data);
            if (frame_err) n_ferr = n_ferr + 1;
            if (overrun) n_ovr = n_ovr + 1;
            if (out_valid) n_vhigh = n_vhigh + 1;
            if (out_valid && !prev_valid) t_valid = cyc;
            prev_valid = out_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic clear_mon();
        got.delete();
        n_ferr  = 0;
        n_ovr   = 0;
        n_vhigh = 0;
        t_valid = -1;
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1 uart_rx = 1'b1;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, output int t_start);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        t_start = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 uart_rx = frame[i];
            if (i == 0) t_start = cyc;
            repeat (CPB - 1) @(posedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; uart_rx = 1'b1; out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b data=%h ferr=%b ovr=%b, required all 0",
                     out_valid, out_data, frame_err, overrun);
        end
        rst = 1'b0;
        idle(10);
    endtask

    task automatic test_basic_word();
        int t0;
        clear_mon();
        out_rdy = 1'b1;
        send_byte(8'h12, 1'b1, t0);
        send_byte(8'h34, 1'b1, t0);
        idle(10);
        checks++;
        if (got.size() != 1 || got[0] !== 16'h1234) begin
            failures++;
            $display("FAIL basic_word: %0d words first=%h, required 1 word 1234", got.size(),
                     got.size() ? got[0] : 16'h0);
        end
        checks++;
        if (t_valid - t0 != LAT) begin
            failures++;
            $display("FAIL basic_latency: %0d clks, required %0d", t_valid - t0, LAT);
        end
        checks++;
        if (n_vhigh != 1 || n_ferr != 0 || n_ovr != 0) begin
            failures++;
            $display("FAIL basic_flags: valid_cycles=%0d ferr=%0d ovr=%0d, required 1/0/0",
                     n_vhigh, n_ferr, n_ovr);
        end
    endtask

    task automatic test_overrun();
        int t0;
        clear_mon();
        out_rdy = 1'b0;
        send_byte(8'hAB, 1'b1, t0);
        send_byte(8'hCD, 1'b1, t0);
        send_byte(8'h11, 1'b1, t0);
        send_byte(8'h22, 1'b1, t0);
        idle(10);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hABCD) begin
            failures++;
            $display("FAIL overrun_hold: valid=%b data=%h, required 1/abcd", out_valid, out_data);
        end
        checks++;
        if (n_ovr != 1 || n_ferr != 0) begin
            failures++;
            $display("FAIL overrun_pulse: ovr=%0d ferr=%0d, required 1/0", n_ovr, n_ferr);
        end
        @(posedge clk); #1 out_rdy = 1'b1;
        @(posedge clk); #1 out_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || got.size() != 1 || (got.size() == 1 && got[0] !== 16'hABCD)) begin
            failures++;
            $display("FAIL overrun_drain: valid=%b accepted=%0d, required 0 and one abcd",
                     out_valid, got.size());
        end
    endtask

    task automatic test_frame_err();
        int t0;
        clear_mon();
        out_rdy = 1'b1;
        send_byte(8'h55, 1'b0, t0);
        idle(40);
        checks++;
        if (n_ferr != 1 || got.size() != 0) begin
            failures++;
            $display("FAIL frame_err_pulse: ferr=%0d words=%0d, required 1/0", n_ferr, got.size());
        end
        send_byte(8'h56, 1'b1, t0);
        send_byte(8'h78, 1'b1, t0);
        idle(10);
        checks++;
        if (got.size() != 1 || got[0] !== 16'h5678) begin
            failures++;
            $display("FAIL frame_err_recover: %0d words first=%h, required 1 word 5678", got.size(),
                     got.size() ? got[0] : 16'h0);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (2) @(posedge clk);
        idle(200);
        checks++;
        if (n_vhigh != 0 || n_ferr != 0) begin
            failures++;
            $display("FAIL glitch: valid_cycles=%0d ferr=%0d, required 0/0", n_vhigh, n_ferr);
        end
    endtask

    task automatic test_timeout();
        int t0;
        clear_mon();
        out_rdy = 1'b1;
        send_byte(8'h9A, 1'b1, t0);
        idle(500);
        send_byte(8'hBC, 1'b1, t0);
        send_byte(8'hDE, 1'b1, t0);
        idle(10);
        checks++;
        if (got.size() != 1 || got[0] !== 16'hBCDE || n_ferr != 0) begin
            failures++;
            $display("FAIL timeout: %0d words first=%h ferr=%0d, required 1 word bcde", got.size(),
                     got.size() ? got[0] : 16'h0, n_ferr);
        end
    endtask

    task automatic test_random_pairs();
        logic [15:0] exp_q[$];
        logic [7:0]  a, b;
        int t0;
        clear_mon();
        out_rdy = 1'b1;
        for (int p = 0; p < 8; p++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            send_byte(a, 1'b1, t0);
            if ($urandom_range(1, 0) == 1) idle($urandom_range(60, 1));
            send_byte(b, 1'b1, t0);
            if ($urandom_range(1, 0) == 1) idle($urandom_range(60, 1));
            exp_q.push_back({a, b});
        end
        idle(10);
        checks++;
        if (got.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count: %0d words, required %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL random_word[%0d]: %h, required %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        clear_mon();
        out_rdy = 1'b0;
        send_byte(8'h01, 1'b1, t0);
        send_byte(8'h02, 1'b1, t0);
        idle(5);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0102) begin
            failures++;
            $display("FAIL midrst_pre: valid=%b data=%h, required 1/0102", out_valid, out_data);
        end
        // 0x12 frame: start bit, bits 0..3, then reset halfway into bit 4.
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (CPB - 1) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 uart_rx = (i == 1);
            repeat (CPB - 1) @(posedge clk);
        end
        @(posedge clk); #1 uart_rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async: valid=%b data=%h ferr=%b ovr=%b, required all 0",
                     out_valid, out_data, frame_err, overrun);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(40);
        clear_mon();
        out_rdy = 1'b1;
        send_byte(8'hCA, 1'b1, t0);
        send_byte(8'hFE, 1'b1, t0);
        idle(10);
        checks++;
        if (got.size() != 1 || got[0] !== 16'hCAFE) begin
            failures++;
            $display("FAIL midrst_recover: %0d words first=%h, required 1 word cafe", got.size(),
                     got.size() ? got[0] : 16'h0);
        end
    endtask

    initial begin
        clear_mon();
        prev_valid = 1'b0;
        test_reset();
        test_basic_word();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_timeout();
        test_random_pairs();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_unpkg.md
Name: uart_unpkg

Overview:
- Receive-side counterpart of the UART word packer.
- Deserialises 8N1 UART bytes from uart_rx and assembles byte pairs into 16-bit words.
- Presents each word on a valid/ready output that feeds the bc_buffer avoid input (in_data/in_valid/in_rdy).
- Runs on the 100 MHz system clock.

Parameters:
- CLKS_PER_BIT, 868: system clocks per UART bit (100 MHz / 115200 baud); must be at least 8.
- TIMEOUT_CLKS, 20000: maximum clocks between the two bytes of one word before the first byte is discarded.

Ports:
- clk  in  1  system clock (CLK100MHZ domain).
- rst  in  1  asynchronous, active-high reset.
- uart_rx  in  1  asynchronous serial input; idles high.
- out_data  out  16  assembled word, {first byte, second byte}.
- out_valid  out  1  out_data holds an unconsumed word.
- out_rdy  in  1  downstream accepts the word when high together with out_valid.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
- overrun  out  1  one-cycle pulse when a completed word is dropped because the output is occupied.

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous and active-high.
- Reset values:
  - out_data = 0, out_valid = 0, frame_err = 0, overrun = 0.
  - rx synchroniser flops = 1, FSM = IDLE, byte phase = 0, all counters = 0.
- Input synchroniser: uart_rx passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s.
- Bit FSM, with bit counter cnt:
  - IDLE: when rx_s == 0, go to START and set cnt = 0.
  - START: at cnt == CLKS_PER_BIT/2 - 1, sample rx_s.
    - Sample 0: go to DATA, cnt = 0, bit index = 0.
    - Sample 1: glitch. Return to IDLE with no error flag.
  - DATA: at cnt == CLKS_PER_BIT - 1, sample rx_s into shift register bit [index], LSB first, and reset cnt.
    - After index 7, go to STOP.
  - STOP: at cnt == CLKS_PER_BIT - 1 (mid stop bit), sample rx_s.
    - Sample 1: byte_done for one cycle.
    - Sample 0: frame_err for one cycle; byte discarded; byte phase forced to 0.
    - Either way, return to IDLE immediately, so back-to-back frames are captured.
- Byte phase:
  - Phase 0: byte_done stores the high byte; phase becomes 1; timeout counter cleared.
  - Phase 1: timeout counter increments every cycle.
    - byte_done: word = {hi, byte}; phase becomes 0.
    - Counter reaching TIMEOUT_CLKS: phase becomes 0 and the high byte is discarded, with no flag.
    - If byte_done and timeout coincide, byte_done wins.
- Output register:
  - word_done with (!out_valid || out_rdy): load out_data and set out_valid = 1. This covers simultaneous consume and load.
  - word_done with out_valid && !out_rdy: word dropped; overrun pulses; out_data unchanged.
  - out_valid && out_rdy with no word_done: out_valid = 0 next cycle; out_data holds its last value.
- Latency: out_valid rises exactly one clk after the mid-stop-bit sample of the second byte.
- Error flags: frame_err and overrun are pulses and can coincide.
- Reset mid-frame: everything returns to reset values immediately. A partially received frame is lost.
  - After reset is released, a line still low mid-byte may be taken as a start bit. The resulting garbage byte can produce frame_err, which is acceptable.
  - Frames that begin after the line returns idle decode correctly.

Decomposition:
- Shared package uart_pkg_defs holds:
  - the bit-FSM state encoding (IDLE, START, DATA, STOP);
  - the default baud constant UART_CLKS_PER_BIT = 868;
  - the word byte-order convention (high byte first), shared with the transmitter.
- One sub-module, uart_rx_byte: synchroniser plus bit FSM, producing byte, byte_done and frame_err.
- uart_unpkg adds the byte phase, the timeout counter and the output register.

Test Plan (CLKS_PER_BIT = 16, TIMEOUT_CLKS = 400 for simulation):
1. out_rdy = 1; send 0x12 then 0x34 back-to-back -> out_data = 0x1234, out_valid high for 1 cycle, arriving 1 clk after the second stop-bit midpoint; no flags.
2. out_rdy = 0; send 0xAB, 0xCD, then 0x11, 0x22 -> out_data stays 0xABCD with out_valid held; overrun pulses once. Then raise out_rdy for 1 cycle -> out_valid drops.
3. Send 0x55 with its stop bit driven 0 -> one frame_err pulse, no word. Then send 0x56, 0x78 -> out_data = 0x5678.
4. Drive uart_rx low for 3 clks and release; wait 200 clks -> no out_valid, no frame_err; FSM back in IDLE.
5. Send 0x9A, idle 500 clks, then send 0xBC, 0xDE -> single word 0xBCDE; 0x9A never appears.
6. Assert rst during bit 4 of the first byte of 0x1234 -> all outputs 0 at once. After release and line idle, send 0xCAFE -> out_data = 0xCAFE.
